// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation and operand-source selects.
package ex_pkg;

  // ALU operation select (5-bit); codes 14-31 are unused and produce zero.
  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluAddu = 5'd1;
  localparam logic [4:0] AluSub  = 5'd2;
  localparam logic [4:0] AluSubu = 5'd3;
  localparam logic [4:0] AluAnd  = 5'd4;
  localparam logic [4:0] AluOr   = 5'd5;
  localparam logic [4:0] AluXor  = 5'd6;
  localparam logic [4:0] AluNor  = 5'd7;
  localparam logic [4:0] AluSlt  = 5'd8;
  localparam logic [4:0] AluSltu = 5'd9;
  localparam logic [4:0] AluSll  = 5'd10;
  localparam logic [4:0] AluSrl  = 5'd11;
  localparam logic [4:0] AluSra  = 5'd12;
  localparam logic [4:0] AluLui  = 5'd13;

  // Operand source select (5-bit); any other value behaves like SrcRsRt.
  localparam logic [4:0] SrcRsRt    = 5'd0;
  localparam logic [4:0] SrcRsSimm  = 5'd1;
  localparam logic [4:0] SrcRsZimm  = 5'd2;
  localparam logic [4:0] SrcShamtRt = 5'd3;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: result, zero and signed-overflow from two operands and an op select.
module ex_alu
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic [4:0]       i_alu_ctrl,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [4:0]       w_shamt;

  assign w_sum   = i_op1 + i_op2;
  assign w_diff  = i_op1 - i_op2;
  assign w_shamt = i_op1[4:0];

  // Operation decode; overflow is only meaningful for the signed add/sub.
  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_alu_ctrl)
      AluAdd: begin
        o_result   = w_sum;
        o_overflow = (i_op1[WIDTH-1] == i_op2[WIDTH-1]) && (w_sum[WIDTH-1] != i_op1[WIDTH-1]);
      end
      AluAddu: o_result = w_sum;
      AluSub: begin
        o_result   = w_diff;
        o_overflow = (i_op1[WIDTH-1] != i_op2[WIDTH-1]) && (w_diff[WIDTH-1] != i_op1[WIDTH-1]);
      end
      AluSubu: o_result = w_diff;
      AluAnd:  o_result = i_op1 & i_op2;
      AluOr:   o_result = i_op1 | i_op2;
      AluXor:  o_result = i_op1 ^ i_op2;
      AluNor:  o_result = ~(i_op1 | i_op2);
      AluSlt:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      AluSltu: o_result = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
      AluSll:  o_result = i_op2 << w_shamt;
      AluSrl:  o_result = i_op2 >> w_shamt;
      AluSra:  o_result = $unsigned($signed(i_op2) >>> w_shamt);
      AluLui:  o_result = i_op2 << 16;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch-target adder and a one-cycle output register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       ALUCtrl,
  input  logic [4:0]       ALUSrc,
  input  logic [WIDTH-1:0] RegReadData1,
  input  logic [WIDTH-1:0] RegReadData2,
  input  logic [4:0]       Shamt,
  input  logic [15:0]      Imm,
  input  logic [WIDTH-1:0] PCPlus4,
  output logic [WIDTH-1:0] ALUOut,
  output logic             ZeroFlag,
  output logic             Overflow,
  output logic [WIDTH-1:0] BranchAddr,
  output logic [WIDTH-1:0] StoreData
);

  logic [WIDTH-1:0] w_imm_sext;
  logic [WIDTH-1:0] w_imm_zext;
  logic [WIDTH-1:0] w_shamt_zext;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_branch;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_overflow;
  logic [WIDTH-1:0] r_branch;
  logic [WIDTH-1:0] r_store;

  assign w_imm_sext   = {{(WIDTH-16){Imm[15]}}, Imm};
  assign w_imm_zext   = {{(WIDTH-16){1'b0}}, Imm};
  assign w_shamt_zext = {{(WIDTH-5){1'b0}}, Shamt};

  // Operand select; unlisted source codes fall back to rs/rt.
  always_comb begin
    w_op1 = RegReadData1;
    w_op2 = RegReadData2;
    case (ALUSrc)
      SrcRsSimm:  w_op2 = w_imm_sext;
      SrcRsZimm:  w_op2 = w_imm_zext;
      SrcShamtRt: w_op1 = w_shamt_zext;
      default: begin
        w_op1 = RegReadData1;
        w_op2 = RegReadData2;
      end
    endcase
  end

  ex_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_op1      (w_op1),
    .i_op2      (w_op2),
    .i_alu_ctrl (ALUCtrl),
    .o_result   (w_result),
    .o_zero     (w_zero),
    .o_overflow (w_overflow)
  );

  // Dedicated branch-target adder, independent of the ALU.
  assign w_branch = PCPlus4 + (w_imm_sext << 2);

  // Output register; synchronous reset wins over the operation presented on the same edge.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_alu_out  <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_branch   <= '0;
      r_store    <= '0;
    end else begin
      r_alu_out  <= w_result;
      r_zero     <= w_zero;
      r_overflow <= w_overflow;
      r_branch   <= w_branch;
      r_store    <= RegReadData2;
    end
  end

  assign ALUOut     = r_alu_out;
  assign ZeroFlag   = r_zero;
  assign Overflow   = r_overflow;
  assign BranchAddr = r_branch;
  assign StoreData  = r_store;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: per-cycle arithmetic model plus hand-computed vectors.
module tb_ex_stage;

  logic        CLOCK;
  logic        RESET;
  logic [4:0]  ALUCtrl;
  logic [4:0]  ALUSrc;
  logic [31:0] RegReadData1;
  logic [31:0] RegReadData2;
  logic [4:0]  Shamt;
  logic [15:0] Imm;
  logic [31:0] PCPlus4;
  logic [31:0] ALUOut;
  logic        ZeroFlag;
  logic        Overflow;
  logic [31:0] BranchAddr;
  logic [31:0] StoreData;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] out;
    logic        z;
    logic        ov;
    logic [31:0] br;
    logic [31:0] sd;
  } exp_t;

  ex_stage #(
    .WIDTH(32)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .ALUCtrl      (ALUCtrl),
    .ALUSrc       (ALUSrc),
    .RegReadData1 (RegReadData1),
    .RegReadData2 (RegReadData2),
    .Shamt        (Shamt),
    .Imm          (Imm),
    .PCPlus4      (PCPlus4),
    .ALUOut       (ALUOut),
    .ZeroFlag     (ZeroFlag),
    .Overflow     (Overflow),
    .BranchAddr   (BranchAddr),
    .StoreData    (StoreData)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Model: wide signed/unsigned integer arithmetic, truncated to 32 bits at the end.
  function automatic exp_t model(input logic rst_n, input logic [4:0] ctrl, input logic [4:0] src,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] sh, input logic [15:0] imm,
                                 input logic [31:0] pc);
    exp_t e;
    logic [31:0] o1, o2;
    longint s1, s2, u1, u2, r, simm;
    logic ov;
    o1 = rs;
    o2 = rt;
    if (src == 5'd1) o2 = {{16{imm[15]}}, imm};
    else if (src == 5'd2) o2 = {16'h0, imm};
    else if (src == 5'd3) o1 = {27'h0, sh};
    s1 = longint'($signed(o1));
    s2 = longint'($signed(o2));
    u1 = longint'(o1);
    u2 = longint'(o2);
    ov = 1'b0;
    case (ctrl)
      5'd0: begin r = s1 + s2; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'd1: r = u1 + u2;
      5'd2: begin r = s1 - s2; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'd3: r = u1 - u2;
      5'd4: r = u1 & u2;
      5'd5: r = u1 | u2;
      5'd6: r = u1 ^ u2;
      5'd7: r = ~(u1 | u2);
      5'd8: r = (s1 < s2) ? 64'd1 : 64'd0;
      5'd9: r = (u1 < u2) ? 64'd1 : 64'd0;
      5'd10: r = u2 << (u1 % 32);
      5'd11: r = u2 >> (u1 % 32);
      5'd12: r = s2 >>> (u1 % 32);
      5'd13: r = u2 * 65536;
      default: r = 0;
    endcase
    simm = longint'($signed(imm));
    e.out = r[31:0];
    e.z   = (r[31:0] == 32'h0);
    e.ov  = ov;
    r     = longint'(pc) + simm * 4;
    e.br  = r[31:0];
    e.sd  = rt;
    if (!rst_n) e = '0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare: the model's view of what was sampled at this edge.
  always @(posedge CLOCK) begin
    exp_t e;
    e = model(RESET, ALUCtrl, ALUSrc, RegReadData1, RegReadData2, Shamt, Imm, PCPlus4);
    #1;
    check("cyc_aluout", ALUOut, e.out);
    check("cyc_zero", {31'h0, ZeroFlag}, {31'h0, e.z});
    check("cyc_ovf", {31'h0, Overflow}, {31'h0, e.ov});
    check("cyc_branch", BranchAddr, e.br);
    check("cyc_store", StoreData, e.sd);
  end

  task automatic set_in(input logic [4:0] ctrl, input logic [4:0] src, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] pc);
    ALUCtrl      = ctrl;
    ALUSrc       = src;
    RegReadData1 = rs;
    RegReadData2 = rt;
    Shamt        = sh;
    Imm          = imm;
    PCPlus4      = pc;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #2;
  endtask

  logic [31:0] rs_tab [4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] rt_tab [4] = '{32'h1, 32'h80000000, 32'h0, 32'hA5A5F00F};
  logic [15:0] im_tab [4] = '{16'h8001, 16'h7FFF, 16'h0000, 16'hFFFC};

  initial begin
    RESET = 1'b0;
    set_in(5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0);
    @(negedge CLOCK);

    // Valid op held during reset: outputs must stay zero.
    set_in(5'd0, 5'd1, 32'd5, 32'h55, 5'd0, 16'hFFFD, 32'h100);
    step();
    check("rst_aluout", ALUOut, 32'h0);
    check("rst_zero", {31'h0, ZeroFlag}, 32'h0);
    check("rst_branch", BranchAddr, 32'h0);
    check("rst_store", StoreData, 32'h0);

    // Release reset with the same op presented: 5 + (-3) appears one edge later.
    RESET = 1'b1;
    step();
    check("addi_out", ALUOut, 32'd2);
    check("addi_zero", {31'h0, ZeroFlag}, 32'h0);
    check("addi_ovf", {31'h0, Overflow}, 32'h0);
    check("addi_store", StoreData, 32'h55);

    set_in(5'd0, 5'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 16'h0, 32'h0);
    step();
    check("add_ovf_out", ALUOut, 32'h80000000);
    check("add_ovf_flag", {31'h0, Overflow}, 32'h1);
    set_in(5'd1, 5'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 16'h0, 32'h0);
    step();
    check("addu_out", ALUOut, 32'h80000000);
    check("addu_flag", {31'h0, Overflow}, 32'h0);

    set_in(5'd12, 5'd3, 32'h0, 32'h80000000, 5'd4, 16'h0, 32'h0);
    step();
    check("sra4", ALUOut, 32'hF8000000);
    set_in(5'd11, 5'd3, 32'h0, 32'h80000000, 5'd4, 16'h0, 32'h0);
    step();
    check("srl4", ALUOut, 32'h08000000);
    set_in(5'd10, 5'd3, 32'h0, 32'h80000000, 5'd0, 16'h0, 32'h0);
    step();
    check("sll0", ALUOut, 32'h80000000);

    set_in(5'd8, 5'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 32'h0);
    step();
    check("slt", ALUOut, 32'h1);
    set_in(5'd9, 5'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 32'h0);
    step();
    check("sltu", ALUOut, 32'h0);
    set_in(5'd2, 5'd0, 32'd7, 32'd7, 5'd0, 16'h0, 32'h0);
    step();
    check("sub_zero_out", ALUOut, 32'h0);
    check("sub_zero_flag", {31'h0, ZeroFlag}, 32'h1);

    set_in(5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 16'hFFFF, 32'h100);
    step();
    check("branch_neg", BranchAddr, 32'hFC);
    set_in(5'd13, 5'd2, 32'h0, 32'h0, 5'd0, 16'h0004, 32'h100);
    step();
    check("branch_pos", BranchAddr, 32'h110);
    check("lui_zimm", ALUOut, 32'h00040000);

    // Mid-stream reset discards the in-flight op.
    set_in(5'd5, 5'd0, 32'h0F0F0000, 32'h000000F0, 5'd0, 16'h1234, 32'h200);
    RESET = 1'b0;
    step();
    check("mid_rst_out", ALUOut, 32'h0);
    check("mid_rst_branch", BranchAddr, 32'h0);
    RESET = 1'b1;
    step();
    check("post_rst_or", ALUOut, 32'h0F0F00F0);

    // Sweep every op code and source code over a small operand table.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 32; c++) begin
        for (int s = 0; s < 8; s++) begin
          set_in(5'(c), 5'(s), rs_tab[k], rt_tab[k], 5'(k * 7 + 3), im_tab[k],
                 32'h0040_0000 + 32'(k * 16));
          step();
        end
      end
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data, PC and result width.
REQ-002 SHALL have port CLOCK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port ALUCtrl, input, 5, ALU operation select (encoding in REQ-012).
REQ-005 SHALL have port ALUSrc, input, 5, operand source select (encoding in REQ-010).
REQ-006 SHALL have port RegReadData1, input, WIDTH, the rs value.
REQ-007 SHALL have port RegReadData2, input, WIDTH, the rt value.
REQ-008 SHALL have ports Shamt (input, 5, shift amount), Imm (input, 16, immediate field), PCPlus4 (input, WIDTH, PC+4 of the instruction).
REQ-009 SHALL have registered outputs ALUOut (WIDTH, result), ZeroFlag (1, result==0), Overflow (1, signed overflow), BranchAddr (WIDTH, branch target), StoreData (WIDTH, registered RegReadData2).

Function
REQ-010 Operand select SHALL be: ALUSrc 0 -> Op1=rs, Op2=rt; 1 -> Op1=rs, Op2=sign-extended Imm; 2 -> Op1=rs, Op2=zero-extended Imm; 3 -> Op1=zero-extended Shamt, Op2=rt; any other value -> same as 0.
REQ-011 Both operands SHALL be treated as signed WIDTH-bit values for signed ops and as unsigned for unsigned ops.
REQ-012 ALUCtrl encoding SHALL be: 0 ADD, 1 ADDU, 2 SUB (Op1-Op2), 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 LUI (Op2<<16); codes 14-31 SHALL give result 0.
REQ-013 Shifts SHALL shift Op2 by Op1[4:0]; a shift of 0 returns Op2 unchanged; SRA replicates Op2[WIDTH-1].
REQ-014 Add/sub SHALL wrap modulo 2^WIDTH; Overflow SHALL be 1 only for ADD/SUB with signed overflow, else 0; the result is still written on overflow.
REQ-015 SLT/SLTU SHALL produce 1 or 0 in bit 0, upper bits 0.
REQ-016 ZeroFlag SHALL be 1 iff the WIDTH-bit result equals 0.
REQ-017 BranchAddr SHALL equal PCPlus4 + (sign-extended Imm << 2), computed by a dedicated adder, modulo 2^WIDTH.
REQ-018 All outputs SHALL be registered with exactly one cycle latency: inputs sampled at edge N appear on outputs after edge N; no handshake, a new operation is accepted every cycle.
REQ-019 Combinational paths from inputs to outputs SHALL not exist.

Reset
REQ-020 When RESET is low at a rising edge, all outputs SHALL become 0 (ZeroFlag included) on that edge.
REQ-021 Reset SHALL take priority over a simultaneous new operation; the first valid output appears one edge after RESET returns high.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result with no partial update.

Structure
REQ-023 ALUCtrl and ALUSrc encodings SHALL be constants in shared package ex_pkg, used by decoder and this block.
REQ-024 The ALU datapath SHALL be one sub-module ex_alu (combinational: Op1, Op2, ALUCtrl -> result, zero, overflow); operand select, branch adder and output register live in ex_stage.

Verification
REQ-025 ALUSrc=1, ALUCtrl=0, rs=5, Imm=16'hFFFD -> next cycle ALUOut=2, ZeroFlag=0, Overflow=0.
REQ-026 ALUSrc=0, ALUCtrl=0, rs=32'h7FFFFFFF, rt=1 -> ALUOut=32'h80000000, Overflow=1; same with ALUCtrl=1 -> Overflow=0.
REQ-027 ALUSrc=3, Shamt=4, rt=32'h80000000: ALUCtrl=12 -> 32'hF8000000; ALUCtrl=11 -> 32'h08000000; Shamt=0, ALUCtrl=10 -> 32'h80000000.
REQ-028 rs=32'hFFFFFFFF, rt=1, ALUSrc=0: ALUCtrl=8 -> 1; ALUCtrl=9 -> 0; ALUCtrl=2 with rs=rt=7 -> ALUOut=0, ZeroFlag=1.
REQ-029 PCPlus4=32'h100, Imm=16'hFFFF -> BranchAddr=32'hFC; Imm=16'h0004 -> 32'h110.
REQ-030 Drive a valid op and RESET=0 on the same edge -> all outputs 0; release reset -> the op presented on the next edge appears one cycle later.
